// File: rtl/alu_pkg.sv
// Shared types for the ALU subsystem: opcode and scheduler state encodings,
// request payload struct, and the arithmetic-opcode helper.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } sched_state_e;

  // One requester's operation payload
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_e           op;
  } alu_req_t;

  // Only ADD/SUB produce a meaningful carry
  function automatic logic is_arith(input alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Request/response channels between the requester clients and the scheduler.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_op  : packed payloads, requester i at [8i+7:8i] / [3i+2:3i]
//   rsp_*               : single valid/ready response channel tagged with rsp_id
// master = requester side, slave = scheduler side.
interface alu_req_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ*3-1:0] req_op;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_result;
  logic                 rsp_carry;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req at or after rr_ptr,
// ascending with wrap.
//   req         : request vector
//   rr_ptr      : highest-priority index
//   grant_valid : any request present
//   grant_id    : index of winner
//   grant       : one-hot of winner (zero when none)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] grant
);

  int unsigned idx;

  // Scan farthest-to-nearest so the nearest hit to rr_ptr is the last write
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    grant       = '0;
    idx         = 0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      idx = (32'(rr_ptr) + k - 32'd1) % NUM_REQ;
      if (req[ID_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
    if (grant_valid) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one registered 8-bit ALU among NUM_REQ requesters with round-robin
// arbitration; returns each result on a tagged valid/ready response channel.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : request/response channels (slave side)
//   alu_a/b    : operands to the ALU, alu_opcode : opcode to the ALU
//   alu_result : ALU registered result, alu_carry : ALU registered carry
//   busy       : high whenever an operation is in flight
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  alu_req_scheduler_if.slave  bus,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [2:0]          alu_opcode,
  input  logic [7:0]          alu_result,
  input  logic                alu_carry,
  output logic                busy
);

  sched_state_e       state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant;
  alu_req_t           req_pl [NUM_REQ];

  alu_req_t           issue_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [7:0]         rsp_result_q;
  logic               rsp_carry_q;
  logic               accept_c;
  logic               hs_c;

  // Unpack flat request buses into per-requester payloads
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_pl[i].a  = bus.req_a[8*i +: 8];
      req_pl[i].b  = bus.req_b[8*i +: 8];
      req_pl[i].op = alu_op_e'(bus.req_op[3*i +: 3]);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (bus.req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant       (grant)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, grant and handshake strobes
  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    accept_c      = 1'b0;
    hs_c          = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid && !rst) begin
          bus.req_ready = grant;
          accept_c      = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: state_d = CAPT;
      CAPT:  state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          hs_c    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch winner payload, capture result, advance pointer on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q      <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      if (accept_c) begin
        issue_q  <= req_pl[grant_id];
        rsp_id_q <= grant_id;
      end
      if (state_q == CAPT) begin
        rsp_result_q <= alu_result;
        // Carry is stale after logical/shift ops; mask it
        rsp_carry_q  <= is_arith(issue_q.op) & alu_carry;
      end
      if (hs_c) begin
        rr_ptr_q <= (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
      end
    end
  end

  assign alu_a          = issue_q.a;
  assign alu_b          = issue_q.b;
  assign alu_opcode     = issue_q.op;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one 8-bit ALU datapath (registered, 1-cycle result, ADD/SUB/AND/OR/XOR/NOT/SLL/SRL on a 3-bit opcode) between NUM_REQ requesters.
- Round-robin arbitration among requesters; winner's operands/opcode driven to the ALU; registered result captured.
- Result returned on a single valid/ready response channel tagged with the requester ID.
- Sits between the requester clients and the ALU instance in the ALU subsystem top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester ID tag

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_a  input  NUM_REQ*8  operand A, requester i at bits [8i+7:8i]
req_b  input  NUM_REQ*8  operand B, same packing
req_op  input  NUM_REQ*3  opcode, requester i at bits [3i+2:3i]
alu_a  output  8  operand A to ALU
alu_b  output  8  operand B to ALU
alu_opcode  output  3  opcode to ALU
alu_result  input  8  ALU registered result
alu_carry  input  1  ALU registered carry
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  requester ID of response
rsp_result  output  8  captured result
rsp_carry  output  1  captured carry (0 for non-arithmetic ops)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, alu_a/alu_b/alu_opcode=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, busy=0; req_ready=0 while rst high. An in-flight operation is dropped; no response is produced for it.
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE: combinational round-robin search over req_valid starting at rr_ptr, ascending, wrapping at NUM_REQ-1 -> 0. If winner g exists: req_ready[g]=1 (only bit set) in the same cycle; at posedge, latch req_a[g], req_b[g], req_op[g] into alu_a/alu_b/alu_opcode, latch g into rsp_id, go ISSUE. No valid request: stay IDLE, req_ready=0.
- req_ready is asserted only in IDLE, and only to the winner. A requester must hold its payload while valid and not ready. Dropping valid before acceptance is allowed and removes it from arbitration.
- ISSUE: alu_* outputs held stable; ALU samples them at this posedge; go CAPT.
- CAPT: alu_result/alu_carry reflect the issued op. Capture rsp_result=alu_result. rsp_carry=alu_carry if opcode is 000 (ADD) or 001 (SUB), else 0; the ALU leaves carry stale on logical/shift ops and this value must not leak. Go RESP.
- RESP: rsp_valid=1; rsp_id/rsp_result/rsp_carry stable until handshake. On rsp_valid&&rsp_ready at posedge: rsp_valid=0, rr_ptr=(rsp_id+1) mod NUM_REQ, go IDLE. No new grant while in RESP.
- Latency: accept edge -> rsp_valid high 3 cycles later. Minimum initiation interval 4 cycles (with rsp_ready held high).
- alu_* outputs retain their last issued value outside ISSUE; they are not cleared after completion.
- rr_ptr updates only on response handshake, never on grant.
- Simultaneous rst and handshake: rst wins.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum: ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, SLL=110, SRL=111.
  - sched_state_e enum: IDLE, ISSUE, CAPT, RESP.
  - is_arith(op) function.
- Sub-module rr_arbiter (NUM_REQ): combinational inputs req vector and rr_ptr; outputs grant_valid, grant_id and a one-hot grant. Instantiated once.

Test Plan:
- Req0 ADD a=0xFF b=0x01 alone -> req_ready[0] same cycle; 3 cycles later rsp_valid=1, rsp_id=0, rsp_result=0x00, rsp_carry=1.
- All 4 requesters valid continuously, rsp_ready=1, distinct ops -> grants in order 0,1,2,3,0, each 4 cycles apart, and each response ID matches that requester's expected result.
- Req1 SUB a=0x03 b=0x05, then req2 AND a=0xF0 b=0x3C with ALU carry still 1 -> SUB gives 0xFE carry 1; AND gives 0x30 with rsp_carry=0.
- rsp_ready low for 5 cycles during RESP with req3 valid -> rsp_valid and payload stable, req_ready stays 0; grant to req3 only after the handshake.
- Pointer wrap: serve req3, then req0 and req3 both valid -> req0 granted first, then req3.
- rst asserted in CAPT -> next cycle all outputs at reset values, no response emitted, next grant starts search from req0.
